// File: rtl/bus_bridge_pkg.sv
// Shared state encoding and parameter checks for the async bus bridges.
// Timing counts are 3 bits wide, so every phase length tops out at 7.
package bus_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER,
    ST_DONE
  } bridge_state_e;

  localparam int CNT_W   = 3;
  localparam int CYC_MAX = 7;

  function automatic bit cyc_ok(int v, int lo);
    return (v >= lo) && (v <= CYC_MAX);
  endfunction

  function automatic bit timing_ok(
    int setup, int strobe, int hold, int recov
  );
    return cyc_ok(setup, 1) && cyc_ok(strobe, 1) &&
           cyc_ok(hold, 1) && cyc_ok(recov, 0);
  endfunction

  function automatic bit width_ok(int dw);
    return (dw == 16) || (dw == 32);
  endfunction

endpackage

// File: rtl/picorv_async_bus_bridge_if.sv
// picorv32 native bus on one side, async SRAM-style pads on the other.
// master = CPU plus pad model, slave = the bridge.
interface picorv_async_bus_bridge_if #(
  parameter int ADDR_W = 19,
  parameter int BUS_DW = 16
);
  logic [ADDR_W-1:0]   sys_addr;
  logic [31:0]         sys_wdata;
  logic [3:0]          sys_wstrb;
  logic                sys_valid;
  logic                sys_ready;
  logic [31:0]         sys_rdata;
  logic                bus_csn;
  logic                bus_rdn;
  logic                bus_wrn;
  logic [BUS_DW/8-1:0] bus_ben_n;
  logic [ADDR_W-2:0]   bus_a;
  logic [BUS_DW-1:0]   bus_dout;
  logic [BUS_DW-1:0]   bus_din;
  logic                bus_dir;
  logic                busy;

  modport master (
    output sys_addr, sys_wdata, sys_wstrb, sys_valid, bus_din,
    input  sys_ready, sys_rdata, bus_csn, bus_rdn, bus_wrn,
    input  bus_ben_n, bus_a, bus_dout, bus_dir, busy
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_wstrb, sys_valid, bus_din,
    output sys_ready, sys_rdata, bus_csn, bus_rdn, bus_wrn,
    output bus_ben_n, bus_a, bus_dout, bus_dir, busy
  );
endinterface

// File: rtl/bus_beat_timer.sv
// Loadable down-counter that parks at zero; zero marks the last cycle
// of the current bus phase.
module bus_beat_timer
  import bus_bridge_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/picorv_async_bus_bridge.sv
// picorv32 native bus to async SRAM-style bus with programmable
// setup/strobe/hold/recovery and optional 32-on-16 beat splitting.
module picorv_async_bus_bridge
  import bus_bridge_pkg::*;
#(
  parameter int ADDR_W       = 19,
  parameter int BUS_DW       = 16,
  parameter int WIDE_SPLIT   = 1,
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 4,
  parameter int HOLD_CYC     = 1,
  parameter int RECOVERY_CYC = 2
) (
  input logic clk,
  input logic rst,
  picorv_async_bus_bridge_if.slave bif
);

  localparam bit SPLIT = (BUS_DW == 16) && (WIDE_SPLIT != 0);
  localparam int BEN_W = BUS_DW / 8;
  localparam int AW    = ADDR_W - 2;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REC_LD    =
    (RECOVERY_CYC > 0) ? CNT_W'(RECOVERY_CYC - 1) : '0;

  generate
    if (!timing_ok(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVERY_CYC) ||
        !width_ok(BUS_DW)) begin : g_bad_cfg
      $error("picorv_async_bus_bridge: illegal parameter set");
    end
  endgenerate

  bridge_state_e state_q, state_d;

  logic             beat_q, beat_d;
  logic             hi_q, hi_d;
  logic             wr_q, wr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;

  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             csn_q, csn_d;
  logic             rdn_q, rdn_d;
  logic             wrn_q, wrn_d;
  logic [BEN_W-1:0] ben_n_q, ben_n_d;
  logic [AW:0]      a_q, a_d;
  logic [BUS_DW-1:0] dout_q, dout_d;
  logic             dir_q, dir_d;

  logic             ld;
  logic [CNT_W-1:0] ld_val;
  logic             tmr_zero;
  logic [1:0]       new_mask;
  logic             go_setup;
  logic             go_next;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^bif.sys_addr[1:0];

  bus_beat_timer u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .zero     (tmr_zero)
  );

  // Bit n set = beat n must run; a write skips halves with no strobes.
  always_comb begin
    new_mask = 2'b01;
    if (bif.sys_wstrb == 4'b0000)
      new_mask = SPLIT ? 2'b11 : 2'b01;
    else if (SPLIT)
      new_mask = {|bif.sys_wstrb[3:2], |bif.sys_wstrb[1:0]};
    else if (BUS_DW == 16)
      new_mask = {1'b0, |bif.sys_wstrb[1:0]};
    else
      new_mask = {1'b0, |bif.sys_wstrb};
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    hi_d     = hi_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    ready_d  = 1'b0;
    rdata_d  = rdata_q;
    csn_d    = csn_q;
    rdn_d    = rdn_q;
    wrn_d    = wrn_q;
    ben_n_d  = ben_n_q;
    a_d      = a_q;
    dout_d   = dout_q;
    dir_d    = dir_q;
    ld       = 1'b0;
    ld_val   = '0;
    go_setup = 1'b0;
    go_next  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bif.sys_valid) begin
          addr_d  = bif.sys_addr[ADDR_W-1:2];
          wdata_d = bif.sys_wdata;
          wstrb_d = bif.sys_wstrb;
          wr_d    = |bif.sys_wstrb;
          hi_d    = new_mask[1];
          if (new_mask == 2'b00) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
          end else begin
            beat_d   = ~new_mask[0];
            go_setup = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d = ST_STROBE;
          ld      = 1'b1;
          ld_val  = STROBE_LD;
          rdn_d   = wr_q;
          wrn_d   = ~wr_q;
        end
      end
      ST_STROBE: begin
        if (tmr_zero) begin
          state_d = ST_HOLD;
          ld      = 1'b1;
          ld_val  = HOLD_LD;
          rdn_d   = 1'b1;
          wrn_d   = 1'b1;
          if (!wr_q) begin
            if (beat_q)
              rdata_d[31:16] = bif.bus_din[15:0];
            else if (SPLIT)
              rdata_d[15:0] = bif.bus_din[15:0];
            else
              rdata_d = 32'(bif.bus_din);
          end
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          if (RECOVERY_CYC != 0) begin
            state_d = ST_RECOVER;
            ld      = 1'b1;
            ld_val  = REC_LD;
            csn_d   = 1'b1;
            ben_n_d = '1;
            dir_d   = 1'b1;
          end else begin
            go_next = 1'b1;
          end
        end
      end
      ST_RECOVER: begin
        if (tmr_zero) go_next = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (go_next) begin
      if (!beat_q && hi_q) begin
        beat_d   = 1'b1;
        go_setup = 1'b1;
      end else begin
        state_d = ST_DONE;
        ready_d = 1'b1;
        csn_d   = 1'b1;
        ben_n_d = '1;
        dir_d   = 1'b1;
      end
    end

    // Beat entry drives every pad output from the latched request.
    if (go_setup) begin
      state_d = ST_SETUP;
      ld      = 1'b1;
      ld_val  = SETUP_LD;
      csn_d   = 1'b0;
      rdn_d   = 1'b1;
      wrn_d   = 1'b1;
      a_d     = {addr_d, beat_d};
      if (wr_d) begin
        ben_n_d = ~(beat_d ? BEN_W'(wstrb_d[3:2])
                           : wstrb_d[BEN_W-1:0]);
        dout_d  = beat_d ? BUS_DW'(wdata_d[31:16])
                         : wdata_d[BUS_DW-1:0];
        dir_d   = 1'b0;
      end else begin
        ben_n_d = '0;
        dir_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= 1'b0;
      hi_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      csn_q   <= 1'b1;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      ben_n_q <= '1;
      a_q     <= '0;
      dout_q  <= '0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      hi_q    <= hi_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      csn_q   <= csn_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
      ben_n_q <= ben_n_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      dir_q   <= dir_d;
    end
  end

  assign bif.sys_ready = ready_q;
  assign bif.sys_rdata = rdata_q;
  assign bif.bus_csn   = csn_q;
  assign bif.bus_rdn   = rdn_q;
  assign bif.bus_wrn   = wrn_q;
  assign bif.bus_ben_n = ben_n_q;
  assign bif.bus_a     = a_q;
  assign bif.bus_dout  = dout_q;
  assign bif.bus_dir   = dir_q;
  assign bif.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_picorv_async_bus_bridge.sv
// Directed bench: default, non-split and fast-timing bridges on one clock,
// with a pad model answering reads per beat address bit.
module tb_picorv_async_bus_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [18:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [2:0]  valid;
  logic [15:0] din_lo, din_hi;
  int sel;
  int cyc = 0;
  int n_err = 0;
  int n_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  picorv_async_bus_bridge_if #(.ADDR_W(19), .BUS_DW(16)) i0 ();
  picorv_async_bus_bridge_if #(.ADDR_W(19), .BUS_DW(16)) i1 ();
  picorv_async_bus_bridge_if #(.ADDR_W(19), .BUS_DW(16)) i2 ();

  assign i0.sys_addr  = addr;
  assign i0.sys_wdata = wdata;
  assign i0.sys_wstrb = wstrb;
  assign i0.sys_valid = valid[0];
  assign i0.bus_din   = i0.bus_a[0] ? din_hi : din_lo;
  assign i1.sys_addr  = addr;
  assign i1.sys_wdata = wdata;
  assign i1.sys_wstrb = wstrb;
  assign i1.sys_valid = valid[1];
  assign i1.bus_din   = i1.bus_a[0] ? din_hi : din_lo;
  assign i2.sys_addr  = addr;
  assign i2.sys_wdata = wdata;
  assign i2.sys_wstrb = wstrb;
  assign i2.sys_valid = valid[2];
  assign i2.bus_din   = i2.bus_a[0] ? din_hi : din_lo;

  picorv_async_bus_bridge u0 (.clk(clk), .rst(rst), .bif(i0));
  picorv_async_bus_bridge #(.WIDE_SPLIT(0)) u1 (
    .clk(clk), .rst(rst), .bif(i1));
  picorv_async_bus_bridge #(.STROBE_CYC(1), .RECOVERY_CYC(0)) u2 (
    .clk(clk), .rst(rst), .bif(i2));

  logic        m_ready, m_csn, m_rdn, m_wrn, m_dir, m_busy;
  logic [31:0] m_rdata;
  logic [1:0]  m_ben;
  logic [17:0] m_a;
  logic [15:0] m_dout;

  always_comb begin
    m_ready = i0.sys_ready; m_rdata = i0.sys_rdata;
    m_csn = i0.bus_csn; m_rdn = i0.bus_rdn; m_wrn = i0.bus_wrn;
    m_ben = i0.bus_ben_n; m_a = i0.bus_a; m_dout = i0.bus_dout;
    m_dir = i0.bus_dir; m_busy = i0.busy;
    if (sel == 1) begin
      m_ready = i1.sys_ready; m_rdata = i1.sys_rdata;
      m_csn = i1.bus_csn; m_rdn = i1.bus_rdn; m_wrn = i1.bus_wrn;
      m_ben = i1.bus_ben_n; m_a = i1.bus_a; m_dout = i1.bus_dout;
      m_dir = i1.bus_dir; m_busy = i1.busy;
    end else if (sel == 2) begin
      m_ready = i2.sys_ready; m_rdata = i2.sys_rdata;
      m_csn = i2.bus_csn; m_rdn = i2.bus_rdn; m_wrn = i2.bus_wrn;
      m_ben = i2.bus_ben_n; m_a = i2.bus_a; m_dout = i2.bus_dout;
      m_dir = i2.bus_dir; m_busy = i2.busy;
    end
  end

  int n_csn0, n_dir0, n_dir_bad, n_rdn, n_wrn, run;
  int wrn_rise, csn_rise;
  bit stb, stb_prev = 1'b0, wrn_prev = 1'b1, csn_prev = 1'b1;
  logic [17:0] st_a[$];
  logic [1:0]  st_ben[$];
  logic [15:0] st_dout[$];
  int runs[$];

  always @(negedge clk) begin
    if (!m_csn) n_csn0++;
    if (!m_dir) n_dir0++;
    if (!m_dir && m_csn) n_dir_bad++;
    if (!m_rdn) n_rdn++;
    if (!m_wrn) n_wrn++;
    stb = !m_rdn || !m_wrn;
    if (stb && !stb_prev) begin
      st_a.push_back(m_a);
      st_ben.push_back(m_ben);
      st_dout.push_back(m_dout);
      run = 0;
    end
    if (stb) run++;
    if (!stb && stb_prev) runs.push_back(run);
    if (m_wrn && !wrn_prev) wrn_rise = cyc;
    if (m_csn && !csn_prev) csn_rise = cyc;
    stb_prev = stb;
    wrn_prev = m_wrn;
    csn_prev = m_csn;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic mon_clear();
    n_csn0 = 0; n_dir0 = 0; n_dir_bad = 0; n_rdn = 0; n_wrn = 0;
    wrn_rise = 0; csn_rise = 0;
    st_a.delete(); st_ben.delete(); st_dout.delete(); runs.delete();
  endtask

  task automatic xact(input string tag, input int s,
                      input logic [18:0] ad, input logic [31:0] wd,
                      input logic [3:0] ws, input int exp_lat,
                      output logic [31:0] rd);
    int t0;
    int lat;
    bit got;
    @(negedge clk);
    #1;
    mon_clear();
    sel = s; addr = ad; wdata = wd; wstrb = ws;
    valid[s] = 1'b1;
    t0 = cyc + 1;
    lat = 999;
    got = 1'b0;
    rd = '0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (m_ready) begin
        got = 1'b1;
        lat = cyc + 1 - t0;
        rd = m_rdata;
        chk({tag, " csn@done"}, 32'(m_csn), 32'd1);
      end
    end
    valid[s] = 1'b0;
    chk({tag, " lat"}, 32'(lat), 32'(exp_lat));
  endtask

  logic [31:0] rd;
  bit seen;
  int nrdy;

  initial begin
    addr = '0; wdata = '0; wstrb = '0; valid = '0;
    din_lo = '0; din_hi = '0; sel = 0;
    repeat (3) @(negedge clk);
    chk("rst csn",   32'(m_csn),   32'd1);
    chk("rst rdn",   32'(m_rdn),   32'd1);
    chk("rst wrn",   32'(m_wrn),   32'd1);
    chk("rst ben",   32'(m_ben),   32'h3);
    chk("rst a",     32'(m_a),     32'd0);
    chk("rst dout",  32'(m_dout),  32'd0);
    chk("rst dir",   32'(m_dir),   32'd1);
    chk("rst ready", 32'(m_ready), 32'd0);
    chk("rst rdata", m_rdata,      32'd0);
    chk("rst busy",  32'(m_busy),  32'd0);
    #1 rst = 1'b0;

    din_lo = 16'hBEEF; din_hi = 16'h1234;
    xact("rd2", 0, 19'h00010, 32'h0, 4'h0, 17, rd);
    chk("rd2 data", rd, 32'h1234BEEF);
    chk("rd2 nstb", 32'(st_a.size()), 32'd2);
    chk("rd2 a0",   32'(st_a[0]), 32'h8);
    chk("rd2 a1",   32'(st_a[1]), 32'h9);
    chk("rd2 run0", 32'(runs[0]), 32'd4);
    chk("rd2 run1", 32'(runs[1]), 32'd4);
    chk("rd2 ben",  32'(st_ben[0]), 32'd0);
    chk("rd2 wrn",  32'(n_wrn), 32'd0);
    chk("rd2 dir",  32'(n_dir0), 32'd0);

    xact("wrhi", 0, 19'h00020, 32'hCAFEF00D, 4'b1100, 9, rd);
    chk("wrhi nstb", 32'(st_a.size()), 32'd1);
    chk("wrhi a",    32'(st_a[0]), 32'h11);
    chk("wrhi dout", 32'(st_dout[0]), 32'hCAFE);
    chk("wrhi ben",  32'(st_ben[0]), 32'd0);
    chk("wrhi run",  32'(runs[0]), 32'd4);
    chk("wrhi dir0", 32'(n_dir0), 32'd6);
    chk("wrhi dirx", 32'(n_dir_bad), 32'd0);
    chk("wrhi rdn",  32'(n_rdn), 32'd0);

    din_lo = 16'h0F0F; din_hi = 16'hF0F0;
    xact("ws0", 0, 19'h00100, 32'hDEADBEEF, 4'b0000, 17, rd);
    chk("ws0 data", rd, 32'hF0F00F0F);
    chk("ws0 wrn",  32'(n_wrn), 32'd0);
    chk("ws0 rdn",  32'(n_rdn), 32'd8);
    chk("ws0 dir",  32'(n_dir0), 32'd0);

    xact("nswr", 1, 19'h00104, 32'h11223344, 4'b0001, 9, rd);
    chk("nswr ben",  32'(st_ben[0]), 32'h2);
    chk("nswr dout", 32'(st_dout[0]), 32'h3344);
    chk("nswr a",    32'(st_a[0]), 32'h82);
    chk("nswr run",  32'(runs[0]), 32'd4);
    chk("nswr hold", 32'(csn_rise - wrn_rise), 32'd1);

    xact("empty", 1, 19'h00200, 32'h55667788, 4'b1100, 1, rd);
    chk("empty csn",  32'(n_csn0), 32'd0);
    chk("empty nstb", 32'(st_a.size()), 32'd0);

    din_lo = 16'h5A5A; din_hi = 16'hFFFF;
    xact("nsrd", 1, 19'h00300, 32'h0, 4'h0, 9, rd);
    chk("nsrd data", rd, 32'h00005A5A);
    chk("nsrd nstb", 32'(st_a.size()), 32'd1);
    chk("nsrd a",    32'(st_a[0]), 32'h180);

    din_lo = 16'h1111; din_hi = 16'h2222;
    xact("fast1", 2, 19'h00010, 32'h0, 4'h0, 7, rd);
    chk("fast1 data", rd, 32'h22221111);
    chk("fast1 run",  32'(runs[0]), 32'd1);
    chk("fast1 csn0", 32'(n_csn0), 32'd6);
    chk("fast1 rdn",  32'(n_rdn), 32'd2);
    din_lo = 16'h3333; din_hi = 16'h4444;
    xact("fast2", 2, 19'h00014, 32'h0, 4'h0, 7, rd);
    chk("fast2 data", rd, 32'h44443333);
    chk("fast2 a0",   32'(st_a[0]), 32'hA);
    chk("fast2 a1",   32'(st_a[1]), 32'hB);

    @(negedge clk);
    #1;
    mon_clear();
    sel = 0; addr = 19'h00010; wstrb = 4'h0;
    valid[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (!m_rdn) seen = 1'b1;
    end
    chk("abort stb", 32'(seen), 32'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort csn",   32'(m_csn),   32'd1);
    chk("abort rdn",   32'(m_rdn),   32'd1);
    chk("abort wrn",   32'(m_wrn),   32'd1);
    chk("abort dir",   32'(m_dir),   32'd1);
    chk("abort ready", 32'(m_ready), 32'd0);
    chk("abort busy",  32'(m_busy),  32'd0);
    #1;
    rst = 1'b0;
    valid[0] = 1'b0;
    nrdy = 0;
    repeat (12) begin
      @(negedge clk);
      if (m_ready) nrdy++;
    end
    chk("abort noready", 32'(nrdy), 32'd0);
    din_lo = 16'hAAAA; din_hi = 16'h5555;
    xact("post", 0, 19'h00010, 32'h0, 4'h0, 17, rd);
    chk("post data", rd, 32'h5555AAAA);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
